// File: rtl/mac_lane_array.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane_array
// Description : Multi-lane multiply-accumulate neuron. Each accepted beat
//               carries LANES activation/weight pairs whose products are
//               summed and accumulated over ACC_LEN beats on top of a signed
//               bias. Optional saturation and ReLU are applied, and one
//               result per group is presented on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_array #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 32,
    parameter int B_BITS       = 15,
    parameter int LANES        = 4,
    parameter int ACC_LEN      = 3,
    parameter int SATURATE     = 1,
    parameter int RELU         = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*IN_BITWIDTH-1:0]        a_in,
    input  logic [LANES*IN_BITWIDTH-1:0]        w_in,
    input  logic signed [B_BITS:0]              bias,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUT_BITWIDTH-1:0]      out_data,
    output logic                                out_sat,
    output logic [31:0]                         beat_cnt
);

    localparam int C_PROD_W = 2 * IN_BITWIDTH;
    localparam int C_SUM_W  = OUT_BITWIDTH + C_PROD_W + $clog2(LANES) + 1;
    localparam logic [31:0] C_LAST_BEAT = 32'(ACC_LEN - 1);

    // Representable result range, sign-extended to the full summation width
    localparam logic signed [C_SUM_W-1:0] C_MAX =
        {{(C_SUM_W-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
    localparam logic signed [C_SUM_W-1:0] C_MIN =
        {{(C_SUM_W-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]                    beat_cnt_q, beat_cnt_d;
    logic signed [C_PROD_W-1:0]     prod_q [LANES];
    logic signed [C_PROD_W-1:0]     prod_d [LANES];
    logic                           p_valid_q, p_valid_d;
    logic                           p_first_q, p_first_d;
    logic                           p_last_q,  p_last_d;
    logic signed [B_BITS:0]         p_bias_q,  p_bias_d;

    logic signed [OUT_BITWIDTH-1:0] acc_q, acc_d;
    logic                           sticky_q, sticky_d;
    logic                           out_valid_q, out_valid_d;
    logic signed [OUT_BITWIDTH-1:0] out_data_q, out_data_d;
    logic                           out_sat_q, out_sat_d;

    logic                           w_accept;
    logic signed [C_PROD_W-1:0]     w_lane_prod [LANES];
    logic signed [C_SUM_W-1:0]      w_sum;
    logic                           w_over;
    logic                           w_under;
    logic                           w_clamp;
    logic                           w_sticky;
    logic signed [OUT_BITWIDTH-1:0] w_result;

    // A held output stalls everything; a last beat sitting in stage P costs one
    // bubble so two group results can never land in the output register together.
    assign in_ready = !(out_valid_q && !out_ready) && !(p_valid_q && p_last_q);
    assign w_accept = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign beat_cnt  = beat_cnt_q;

    // Per-lane full-precision signed products
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_prod[gi] = $signed(a_in[gi*IN_BITWIDTH +: IN_BITWIDTH])
                                   * $signed(w_in[gi*IN_BITWIDTH +: IN_BITWIDTH]);
        end
    endgenerate

    // Stage P: capture products, group position flags and bias on accepted beats
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        p_valid_d  = 1'b0;
        p_first_d  = p_first_q;
        p_last_d   = p_last_q;
        p_bias_d   = p_bias_q;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = prod_q[i];
        end
        if (w_accept) begin
            p_valid_d = 1'b1;
            p_first_d = (beat_cnt_q == '0);
            p_last_d  = (beat_cnt_q == C_LAST_BEAT);
            if (beat_cnt_q == '0) begin
                p_bias_d = bias;
            end
            for (int i = 0; i < LANES; i++) begin
                prod_d[i] = w_lane_prod[i];
            end
            beat_cnt_d = (beat_cnt_q == C_LAST_BEAT) ? '0 : beat_cnt_q + 32'd1;
        end
    end

    // Stage A arithmetic: full-width sum, then clamp or wrap to the result width
    always_comb begin
        w_sum = p_first_q ? C_SUM_W'(p_bias_q) : C_SUM_W'(acc_q);
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + C_SUM_W'(prod_q[i]);
        end
        w_over  = (w_sum > C_MAX);
        w_under = (w_sum < C_MIN);
        if (SATURATE != 0) begin
            w_clamp = w_over || w_under;
            if (w_over) begin
                w_result = C_MAX[OUT_BITWIDTH-1:0];
            end else if (w_under) begin
                w_result = C_MIN[OUT_BITWIDTH-1:0];
            end else begin
                w_result = w_sum[OUT_BITWIDTH-1:0];
            end
        end else begin
            w_clamp  = 1'b0;
            w_result = w_sum[OUT_BITWIDTH-1:0];
        end
        // Sticky clamp flag restarts with each group's first beat
        w_sticky = (p_first_q ? 1'b0 : sticky_q) || w_clamp;
    end

    // Stage A state update and output register with valid/ready hold
    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (p_valid_q) begin
            acc_d    = w_result;
            sticky_d = w_sticky;
            if (p_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = ((RELU != 0) && w_result[OUT_BITWIDTH-1]) ? '0 : w_result;
                out_sat_d   = w_sticky;
            end
        end
    end

    // State registers with synchronous reset; a partial group is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_bias_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_bias_q    <= p_bias_d;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_lane_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_lane_array
// Description : Directed bench for mac_lane_array. Three instances cover the
//               saturating default, a single-beat wrapping ReLU variant and a
//               three-beat wrapping variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_lane_array;

    logic                clk;
    logic                rst;
    logic [63:0]         a_in;
    logic [63:0]         w_in;
    logic signed [15:0]  bias;
    logic                iv   [3];
    logic                ordy [3];
    logic                ir   [3];
    logic                ov   [3];
    logic                os   [3];
    logic signed [31:0]  od   [3];
    logic [31:0]         bc   [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0]        a;
        logic [63:0]        w;
        logic signed [15:0] b;
        longint             exp_sat;
        logic               exp_flag;
        longint             exp_wrap;
    } vec_t;

    vec_t tbl [6];

    // Saturating, ACC_LEN=3, no ReLU
    mac_lane_array u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a_in(a_in), .w_in(w_in), .bias(bias),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_sat(os[0]), .beat_cnt(bc[0])
    );

    // Single beat per group, wrapping, ReLU
    mac_lane_array #(.ACC_LEN(1), .SATURATE(0), .RELU(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a_in(a_in), .w_in(w_in), .bias(bias),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_sat(os[1]), .beat_cnt(bc[1])
    );

    // Wrapping, ACC_LEN=3
    mac_lane_array #(.ACC_LEN(3), .SATURATE(0), .RELU(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a_in(a_in), .w_in(w_in), .bias(bias),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .out_sat(os[2]), .beat_cnt(bc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_beat(input int d, input logic [63:0] a, input logic [63:0] w,
                             input logic signed [15:0] b);
        bit ok;
        ok    = 1'b0;
        a_in  = a;
        w_in  = w;
        bias  = b;
        iv[d] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (ir[d]) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        iv[d] = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic run_group(input int d, input logic [63:0] a, input logic [63:0] w,
                             input logic signed [15:0] b, input longint exp_d,
                             input logic exp_s, input string nm);
        int n;
        n = (d == 1) ? 1 : 3;
        for (int k = 0; k < n; k++) begin
            send_beat(d, a, w, b);
            chk({nm, "_beatcnt"}, bc[d], (k + 1) % n);
        end
        chk({nm, "_lastblk"}, ir[d], 0);
        chk({nm, "_lat1"}, ov[d], 0);
        tick();
        chk({nm, "_lat2"}, ov[d], 1);
        chk({nm, "_data"}, od[d], exp_d);
        chk({nm, "_sat"}, os[d], exp_s);
        tick();
        chk({nm, "_drain"}, ov[d], 0);
    endtask

    initial begin
        int n_acc;
        int n_res;

        tbl[0] = '{pk(1, 2, 3, 4), pk(1, 1, 1, 1), 16'sd10,
                   64'sd40, 1'b0, 64'sd40};
        tbl[1] = '{pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767), 16'sd0,
                   -64'sd2147483648, 1'b1, 64'sd393216};
        tbl[2] = '{pk(5, -6, 7, -8), pk(100, 100, 100, 100), -16'sd100,
                   -64'sd700, 1'b0, -64'sd700};
        tbl[3] = '{pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767), 16'sd32767,
                   64'sd2147483647, 1'b1, -64'sd753653};
        tbl[4] = '{pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), -16'sd32768,
                   64'sd2147483647, 1'b1, -64'sd32768};
        tbl[5] = '{pk(0, 0, 0, 0), pk(0, 0, 0, 0), -16'sd5,
                   -64'sd5, 1'b0, -64'sd5};

        rst  = 1'b1;
        a_in = '0;
        w_in = '0;
        bias = '0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", ov[d], 0);
            chk("rst_data", od[d], 0);
            chk("rst_beatcnt", bc[d], 0);
            chk("rst_ready", ir[d], 1);
        end

        // Table: each group on the saturating and the wrapping three-beat units
        for (int v = 0; v < 6; v++) begin
            run_group(0, tbl[v].a, tbl[v].w, tbl[v].b, tbl[v].exp_sat, tbl[v].exp_flag,
                      $sformatf("sat_v%0d", v));
            run_group(2, tbl[v].a, tbl[v].w, tbl[v].b, tbl[v].exp_wrap, 1'b0,
                      $sformatf("wrap_v%0d", v));
        end

        // Single-beat unit: wrap, ReLU clip, positive pass-through
        run_group(1, tbl[1].a, tbl[1].w, 16'sd0, 64'sd131072, 1'b0, "acc1_wrap");
        run_group(1, pk(0, 0, 0, 0), pk(0, 0, 0, 0), -16'sd5, 64'sd0, 1'b0, "acc1_relu");
        run_group(1, pk(1, 0, 0, 0), pk(7, 0, 0, 0), -16'sd5, 64'sd2, 1'b0, "acc1_pos");

        // Backpressure: result held, input stalled, then released
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) send_beat(0, tbl[0].a, tbl[0].w, tbl[0].b);
        tick();
        chk("bp_valid", ov[0], 1);
        chk("bp_data", od[0], 40);
        a_in  = pk(9, 9, 9, 9);
        w_in  = pk(9, 9, 9, 9);
        iv[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_ready", ir[0], 0);
            chk("bp_hold_data", od[0], 40);
            chk("bp_hold_valid", ov[0], 1);
            tick();
        end
        chk("bp_no_beat", bc[0], 0);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        #1;
        chk("bp_release_ready", ir[0], 1);
        tick();
        chk("bp_accepted", ov[0], 0);
        run_group(0, tbl[2].a, tbl[2].w, tbl[2].b, -64'sd700, 1'b0, "bp_next");

        // ACC_LEN=1 streaming: one result every two cycles, no beat lost
        a_in  = pk(2, 2, 2, 2);
        w_in  = pk(3, 3, 3, 3);
        bias  = 16'sd0;
        iv[1] = 1'b1;
        n_acc = 0;
        n_res = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ov[1]) begin
                n_res++;
                chk("stream_data", od[1], 24);
            end
            if (ir[1]) n_acc++;
            tick();
        end
        iv[1] = 1'b0;
        #1;
        chk("stream_accepts", n_acc, 10);
        chk("stream_results", n_res, 9);
        chk("stream_tail_valid", ov[1], 1);
        chk("stream_tail_data", od[1], 24);
        tick();

        // Reset held three cycles in the middle of a group
        send_beat(0, tbl[1].a, tbl[1].w, tbl[1].b);
        send_beat(0, tbl[1].a, tbl[1].w, tbl[1].b);
        chk("mid_beatcnt", bc[0], 2);
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst3_valid", ov[0], 0);
        chk("rst3_data", od[0], 0);
        chk("rst3_sat", os[0], 0);
        chk("rst3_beatcnt", bc[0], 0);
        chk("rst3_ready", ir[0], 1);
        chk("rst3_data_wrap", od[2], 0);

        // One-cycle reset mid-group: earlier beats must not leak into the result
        send_beat(0, tbl[1].a, tbl[1].w, tbl[1].b);
        send_beat(0, tbl[1].a, tbl[1].w, tbl[1].b);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_group(0, tbl[0].a, tbl[0].w, tbl[0].b, 64'sd40, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
